// File: rtl/free_list_ctrl.sv
// Rename-stage free list controller: seeds non-architectural IDs, then serves alloc/release/rollback.
// Optional macro FREE_LIST_STATS_EN adds a saturating 32-bit empty-list stall counter.
module free_list_ctrl #(
  parameter int unsigned NUM_PHYS = 64,
  parameter int unsigned NUM_ARCH = 32,
  localparam int unsigned PHYS_W = $clog2(NUM_PHYS)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef FREE_LIST_STATS_EN
  output logic [31:0]       o_stall_cycles,
`endif
  input  logic              i_alloc_req,
  output logic              o_alloc_ack,
  output logic [PHYS_W-1:0] o_alloc_phys_id,
  input  logic              i_alloc_rollback,
  input  logic              i_release_valid,
  input  logic [PHYS_W-1:0] i_release_phys_id,
  output logic              o_release_ready,
  output logic              o_init_done,
  output logic [PHYS_W:0]   o_free_count,
  output logic              o_fl_push,
  output logic              o_fl_potential_push,
  output logic [PHYS_W-1:0] o_fl_data_in,
  output logic              o_fl_pop,
  output logic              o_fl_rollback,
  input  logic              i_fl_valid,
  input  logic              i_fl_full,
  input  logic [PHYS_W-1:0] i_fl_data_out
);

  typedef enum logic {StInit, StRun} state_e;

  state_e              r_state;
  logic [PHYS_W-1:0]   r_seed_id;
  logic [PHYS_W:0]     r_free_count;
  logic                r_init_done;
  logic                r_rel_v;
  logic [PHYS_W-1:0]   r_rel_id;
  logic                r_last_ack;
  logic                r_any_alloc;

  logic                w_run;
  logic                w_init;
  logic                w_alloc_ack;
  logic                w_rel_accept;
  logic                w_push;
  logic                w_rollback;
  logic [PHYS_W:0]     w_count_next;

  // Every output is forced low while rst is held, whatever state the flops hold.
  assign w_run        = ~rst & (r_state == StRun);
  assign w_init       = ~rst & (r_state == StInit);
  assign w_alloc_ack  = w_run & i_alloc_req & i_fl_valid;
  assign w_rel_accept = w_run & i_release_valid;
  assign w_push       = w_init | (w_run & r_rel_v);
  assign w_rollback   = w_run & i_alloc_rollback & r_last_ack;
  assign w_count_next = r_free_count + (PHYS_W+1)'(w_push) - (PHYS_W+1)'(w_alloc_ack)
                        + (PHYS_W+1)'(w_rollback);

  assign o_alloc_ack         = w_alloc_ack;
  assign o_alloc_phys_id     = rst ? '0 : i_fl_data_out;
  assign o_release_ready     = w_run;
  assign o_init_done         = ~rst & r_init_done;
  assign o_free_count        = rst ? '0 : r_free_count;
  assign o_fl_push           = w_push;
  assign o_fl_potential_push = w_push;
  assign o_fl_data_in        = w_init ? r_seed_id : (w_run ? r_rel_id : '0);
  assign o_fl_pop            = w_alloc_ack;
  assign o_fl_rollback       = w_rollback;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StInit;
      r_seed_id    <= PHYS_W'(NUM_ARCH);
      r_free_count <= '0;
      r_init_done  <= 1'b0;
      r_rel_v      <= 1'b0;
      r_rel_id     <= '0;
      r_last_ack   <= 1'b0;
      r_any_alloc  <= 1'b0;
    end else begin
      r_free_count <= w_count_next;
      r_last_ack   <= w_alloc_ack;
      r_rel_v      <= w_rel_accept;
      if (w_rel_accept) r_rel_id <= i_release_phys_id;
      if (w_alloc_ack) r_any_alloc <= 1'b1;
      if (r_state == StInit) begin
        r_seed_id <= r_seed_id + 1'b1;
        if (r_seed_id == PHYS_W'(NUM_PHYS - 1)) begin
          r_state     <= StRun;
          r_init_done <= 1'b1;
        end
      end
    end
  end

`ifdef FREE_LIST_STATS_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_run && i_alloc_req && !i_fl_valid && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign o_stall_cycles = rst ? '0 : r_stall_cycles;
`endif

  a_no_overflow_push: assert property (@(posedge clk) disable iff (rst)
    !(w_push && i_fl_full && !w_alloc_ack));
  a_ack_needs_valid: assert property (@(posedge clk) disable iff (rst)
    w_alloc_ack |-> i_fl_valid);
  // Architectural IDs only become releasable once something has been renamed.
  a_arch_release: assert property (@(posedge clk) disable iff (rst)
    (w_rel_accept && (i_release_phys_id < PHYS_W'(NUM_ARCH))) |-> r_any_alloc);

endmodule
